// File: rtl/mult2x2_seq_ctrl.sv
// Sequencer that forms a WIDTH x WIDTH unsigned product from one external 2x2
// multiplier cell, feeding it one digit pair per clock and shift-accumulating.
module mult2x2_seq_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [1:0]           pp_a,
  output logic [1:0]           pp_b,
  input  logic [3:0]           pp_q,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned N  = WIDTH / 2;
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned SW = IW + 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
    $error("mult2x2_seq_ctrl: WIDTH must be even and >= 2");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IW-1:0]    r_i;
  logic [IW-1:0]    r_j;
  logic [PW-1:0]    r_acc;
  logic [PW-1:0]    r_product;
  logic [1:0]       r_pp_a;
  logic [1:0]       r_pp_b;
  logic             r_busy;
  logic             r_done;

  logic             w_accept;
  logic             w_last;
  logic [SW-1:0]    w_sum;
  logic [PW-1:0]    w_acc_sum;
  logic [IW-1:0]    w_i_nxt;
  logic [IW-1:0]    w_j_nxt;
  logic [WIDTH-1:0] w_a_src;
  logic [WIDTH-1:0] w_b_src;
  logic [1:0]       w_pp_a_nxt;
  logic [1:0]       w_pp_b_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;

  assign w_accept  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last    = (r_i == LAST) && (r_j == LAST);
  assign w_sum     = SW'(r_i) + SW'(r_j);
  // Digit pair (i,j) carries weight 4^(i+j).
  assign w_acc_sum = r_acc + (PW'(pp_q) << {w_sum, 1'b0});

  // State register plus registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pp_a  <= '0;
      r_pp_b  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_pp_a  <= w_pp_a_nxt;
      r_pp_b  <= w_pp_b_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = start ? S_RUN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Digit index walk: j inner, i outer
  always_comb begin
    w_i_nxt = r_i;
    w_j_nxt = r_j;
    if (w_accept) begin
      w_i_nxt = '0;
      w_j_nxt = '0;
    end else if (r_state == S_RUN) begin
      if (r_j == LAST) begin
        w_j_nxt = '0;
        w_i_nxt = (r_i == LAST) ? '0 : r_i + 1'b1;
      end else begin
        w_j_nxt = r_j + 1'b1;
      end
    end
  end

  // Output logic; digits for the next cycle come from fresh operands on accept
  always_comb begin
    w_a_src    = w_accept ? a : r_a;
    w_b_src    = w_accept ? b : r_b;
    w_busy_nxt = (w_state_nxt == S_RUN);
    w_done_nxt = (w_state_nxt == S_DONE);
    w_pp_a_nxt = '0;
    w_pp_b_nxt = '0;
    if (w_busy_nxt) begin
      w_pp_a_nxt = 2'(w_a_src >> {w_i_nxt, 1'b0});
      w_pp_b_nxt = 2'(w_b_src >> {w_j_nxt, 1'b0});
    end
  end

  // Operand capture, index and accumulator datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_i       <= '0;
      r_j       <= '0;
      r_acc     <= '0;
      r_product <= '0;
    end else begin
      r_i <= w_i_nxt;
      r_j <= w_j_nxt;
      if (w_accept) begin
        r_a   <= a;
        r_b   <= b;
        r_acc <= '0;
      end else if (r_state == S_RUN) begin
        r_acc <= w_acc_sum;
        if (w_last) r_product <= w_acc_sum;
      end
    end
  end

  assign pp_a    = r_pp_a;
  assign pp_b    = r_pp_b;
  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;

endmodule
